// File: rtl/dcc_pkg.sv
// rtl/dcc_pkg.sv - shared FSM state type and default parameters for down_count_checker
package dcc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACQ  = 2'd1,
      LOCK = 2'd2
   } dcc_state_t;

   localparam int DCC_WIDTH       = 4;
   localparam int DCC_CNT_RST_VAL = 0;
   localparam int DCC_LOCK_N      = 3;
   localparam int DCC_WRAP_W      = 8;
   localparam int DCC_ERR_W       = 8;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter; a clear on the same edge as an increment leaves 1
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= W'(inc);
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/down_count_checker.sv
// rtl/down_count_checker.sv - lock/verify checker for a down counter bus; DCC_HOLD_OK_EN makes a stalled count neutral
module down_count_checker
   import dcc_pkg::*;
#(
   parameter int WIDTH       = DCC_WIDTH,
   parameter int CNT_RST_VAL = DCC_CNT_RST_VAL,
   parameter int LOCK_N      = DCC_LOCK_N,
   parameter int WRAP_W      = DCC_WRAP_W,
   parameter int ERR_W       = DCC_ERR_W
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cnt_rstn,
   input  logic [WIDTH-1:0]  cnt_in,
   input  logic              clr,
   output logic              locked,
   output logic              wrap_pulse,
   output logic [WRAP_W-1:0] wrap_cnt,
   output logic              err,
   output logic [ERR_W-1:0]  err_cnt
);

   localparam int MW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(CNT_RST_VAL);

   dcc_state_t       state, state_nxt;
   logic [WIDTH-1:0] prev, prev_nxt, exp_val;
   logic [MW-1:0]    match_cnt, match_nxt, match_inc;
   logic             hold, err_ev, wrap_ev;

   assign exp_val   = prev - 1'b1;
   assign match_inc = match_cnt + 1'b1;
   assign locked    = (state == LOCK);

`ifdef DCC_HOLD_OK_EN
   assign hold = (cnt_in == prev);
`else
   assign hold = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // While the counter is held in reset its bus can only legally show RST_VAL, so that is the baseline.
   always_comb begin
      state_nxt = state;
      match_nxt = match_cnt;
      prev_nxt  = cnt_in;
      err_ev    = 1'b0;
      wrap_ev   = 1'b0;
      if (!cnt_rstn) begin
         state_nxt = IDLE;
         match_nxt = '0;
         prev_nxt  = RST_VAL;
      end else begin
         wrap_ev = (state != IDLE) && (prev == '0) && (cnt_in == CNT_MAX);
         case (state)
            IDLE: state_nxt = ACQ;
            ACQ: begin
               if (cnt_in == exp_val) begin
                  match_nxt = match_inc;
                  if (match_inc == MW'(LOCK_N)) state_nxt = LOCK;
               end else if (!hold) begin
                  match_nxt = '0;
               end
            end
            LOCK: begin
               if ((cnt_in != exp_val) && !hold) begin
                  err_ev    = 1'b1;
                  match_nxt = '0;
                  state_nxt = ACQ;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         prev       <= '0;
         match_cnt  <= '0;
         wrap_pulse <= 1'b0;
         wrap_cnt   <= '0;
         err        <= 1'b0;
      end else begin
         prev       <= prev_nxt;
         match_cnt  <= match_nxt;
         wrap_pulse <= wrap_ev;
         wrap_cnt   <= (clr ? '0 : wrap_cnt) + WRAP_W'(wrap_ev);
         err        <= (err & ~clr) | err_ev;
      end
   end

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clk (clk),
      .rst (rstn),
      .clr (clr),
      .inc (err_ev),
      .cnt (err_cnt)
   );

endmodule

// File: tb/tb_down_count_checker.sv
// tb/tb_down_count_checker.sv - directed self-checking bench for down_count_checker
module tb_down_count_checker;
   import dcc_pkg::*;

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic       cnt_rstn = 1'b0;
   logic [3:0] cnt_in = 4'd0;
   logic       clr = 1'b0;

   logic       locked0, wrap_pulse0, err0;
   logic [7:0] wrap_cnt0, err_cnt0;
   logic       locked1, wrap_pulse1, err1;
   logic [7:0] wrap_cnt1;
   logic [1:0] err_cnt1;

   int checks = 0;
   int errors = 0;
   logic [3:0] v;
   int hold_ok;

   always #5 clk = ~clk;

   down_count_checker d0 (
      .clk(clk), .rstn(rstn), .cnt_rstn(cnt_rstn), .cnt_in(cnt_in), .clr(clr),
      .locked(locked0), .wrap_pulse(wrap_pulse0), .wrap_cnt(wrap_cnt0),
      .err(err0), .err_cnt(err_cnt0)
   );

   down_count_checker #(.ERR_W(2)) d1 (
      .clk(clk), .rstn(rstn), .cnt_rstn(cnt_rstn), .cnt_in(cnt_in), .clr(clr),
      .locked(locked1), .wrap_pulse(wrap_pulse1), .wrap_cnt(wrap_cnt1),
      .err(err1), .err_cnt(err_cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic cr, input logic [3:0] val, input logic c);
      cnt_rstn = cr;
      cnt_in   = val;
      clr      = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
`ifdef DCC_HOLD_OK_EN
      hold_ok = 1;
`else
      hold_ok = 0;
`endif
      // reset with random inputs
      rstn = 1'b1;
      for (int i = 0; i < 2; i++) cyc(1'($urandom), 4'($urandom), 1'($urandom));
      chk("rst_locked", 32'(locked0), 0);
      chk("rst_wrap_pulse", 32'(wrap_pulse0), 0);
      chk("rst_wrap_cnt", 32'(wrap_cnt0), 0);
      chk("rst_err", 32'(err0), 0);
      chk("rst_err_cnt", 32'(err_cnt0), 0);
      chk("rst_state", 32'(d0.state), 32'(IDLE));
      rstn = 1'b0;

      // acquisition across a wrap
      cyc(1'b0, 4'd0, 1'b0);
      cyc(1'b0, 4'd0, 1'b0);
      cyc(1'b1, 4'd0, 1'b0);
      chk("rel_state_acq", 32'(d0.state), 32'(ACQ));
      cyc(1'b1, 4'd15, 1'b0);
      chk("wrap_pulse_15", 32'(wrap_pulse0), 1);
      chk("wrap_cnt_15", 32'(wrap_cnt0), 1);
      chk("locked_after_15", 32'(locked0), 0);
      cyc(1'b1, 4'd14, 1'b0);
      chk("wrap_pulse_14", 32'(wrap_pulse0), 0);
      chk("locked_after_14", 32'(locked0), 0);
      cyc(1'b1, 4'd13, 1'b0);
      chk("locked_after_13", 32'(locked0), 1);
      chk("err_after_13", 32'(err0), 0);
      chk("wrap_cnt_13", 32'(wrap_cnt0), 1);

      // lock break by a skip, then relock
      cyc(1'b1, 4'd12, 1'b0);
      cyc(1'b1, 4'd11, 1'b0);
      cyc(1'b1, 4'd10, 1'b0);
      chk("locked_at_10", 32'(locked0), 1);
      cyc(1'b1, 4'd8, 1'b0);
      chk("skip_err", 32'(err0), 1);
      chk("skip_err_cnt", 32'(err_cnt0), 1);
      chk("skip_locked", 32'(locked0), 0);
      cyc(1'b1, 4'd7, 1'b0);
      chk("relock_7", 32'(locked0), 0);
      cyc(1'b1, 4'd6, 1'b0);
      cyc(1'b1, 4'd5, 1'b0);
      chk("relock_5", 32'(locked0), 1);
      chk("relock_err_cnt", 32'(err_cnt0), 1);

      // counter reset while locked is not an error
      cyc(1'b0, 4'd0, 1'b0);
      chk("cntrst_locked", 32'(locked0), 0);
      chk("cntrst_err", 32'(err0), 1);
      chk("cntrst_err_cnt", 32'(err_cnt0), 1);
      chk("cntrst_state", 32'(d0.state), 32'(IDLE));
      cyc(1'b1, 4'd0, 1'b0);
      cyc(1'b1, 4'd15, 1'b0);
      cyc(1'b1, 4'd14, 1'b0);
      cyc(1'b1, 4'd13, 1'b0);
      chk("cntrst_relock", 32'(locked0), 1);
      chk("cntrst_wrap_cnt", 32'(wrap_cnt0), 2);
      chk("cntrst_err_cnt2", 32'(err_cnt0), 1);

      // stalled count
      cyc(1'b1, 4'd12, 1'b0);
      cyc(1'b1, 4'd11, 1'b0);
      cyc(1'b1, 4'd10, 1'b0);
      cyc(1'b1, 4'd9, 1'b0);
      cyc(1'b1, 4'd9, 1'b0);
      cyc(1'b1, 4'd8, 1'b0);
      chk("hold_err_cnt", 32'(err_cnt0), (hold_ok != 0) ? 1 : 2);
      chk("hold_locked", 32'(locked0), (hold_ok != 0) ? 1 : 0);

      // saturation on the 2-bit error counter, then clear behaviour
      rstn = 1'b1;
      cyc(1'b0, 4'd0, 1'b0);
      rstn = 1'b0;
      cyc(1'b0, 4'd0, 1'b0);
      cyc(1'b1, 4'd0, 1'b0);
      cyc(1'b1, 4'd15, 1'b0);
      cyc(1'b1, 4'd14, 1'b0);
      cyc(1'b1, 4'd13, 1'b0);
      chk("sat_start_locked", 32'(locked1), 1);
      v = 4'd13;
      for (int i = 0; i < 5; i++) begin
         v = v - 4'd5;
         cyc(1'b1, v, 1'b0);
         for (int j = 0; j < 3; j++) begin
            v = v - 4'd1;
            cyc(1'b1, v, 1'b0);
         end
      end
      chk("sat_err_cnt", 32'(err_cnt1), 3);
      chk("sat_err_cnt_wide", 32'(err_cnt0), 5);
      chk("sat_err", 32'(err1), 1);
      chk("sat_locked", 32'(locked1), 1);
      chk("sat_wrap_cnt", 32'(wrap_cnt1), 3);
      cyc(1'b1, 4'd0, 1'b1);
      chk("clr_ev_err_cnt", 32'(err_cnt1), 1);
      chk("clr_ev_err", 32'(err1), 1);
      chk("clr_ev_wrap_cnt", 32'(wrap_cnt1), 0);
      cyc(1'b1, 4'd7, 1'b1);
      chk("clr_err_cnt", 32'(err_cnt1), 0);
      chk("clr_err", 32'(err1), 0);
      cyc(1'b1, 4'd0, 1'b0);
      cyc(1'b1, 4'd15, 1'b1);
      chk("clr_wrap_cnt", 32'(wrap_cnt1), 1);
      chk("clr_wrap_pulse", 32'(wrap_pulse1), 1);
      cyc(1'b1, 4'd14, 1'b0);
      chk("wrap_pulse_single", 32'(wrap_pulse1), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
